// File: rtl/dpu_pkg.sv
// Purpose : shared encodings and field layout for the DPU operand entry path.
// Latency : n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
//
// Contents:
//   state_t        entry FSM state encoding (also driven out as the stage display)
//   AIN/BIN/OP_LSB bit positions of the operand fields inside the DPU data word
//   pack_din()     builds the DPU data word from the three operand registers
package dpu_pkg;

  localparam int DIN_W   = 16;
  localparam int NIB_W   = 4;
  localparam int AIN_LSB = 0;
  localparam int BIN_LSB = 4;
  localparam int OP_LSB  = 8;
  localparam int OP_W    = 3;

  // Encoding is visible on the stage output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_A   = 2'b00,
    ST_B   = 2'b01,
    ST_OP  = 2'b10,
    ST_RUN = 2'b11
  } state_t;

  // Unused upper bits of the word are forced to zero.
  function automatic logic [DIN_W-1:0] pack_din(
    input logic [NIB_W-1:0] a,
    input logic [NIB_W-1:0] b,
    input logic [OP_W-1:0]  op
  );
    logic [DIN_W-1:0] w;
    w = '0;
    w[AIN_LSB +: NIB_W] = a;
    w[BIN_LSB +: NIB_W] = b;
    w[OP_LSB  +: OP_W]  = op;
    return w;
  endfunction

endpackage

// File: rtl/dpu_operand_loader_btn_debounce.sv
// Purpose : synchronise, debounce and edge-detect one raw push-button.
// Latency : raw edge -> pulse = 2 (sync) + DEB_CYCLES (debounce) + 1 (edge) cycles.
// Backpressure: none; one pulse per debounced press, held buttons do not repeat.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   btn_raw     asynchronous, bouncing button input
//   level       debounced button level (registered)
//   pulse       single-cycle pulse on each rising edge of level (registered)
module btn_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  if (DEB_CYCLES < 2) begin : g_deb_min
    $error("btn_debounce: DEB_CYCLES must be at least 2");
  end
  if ((1 << CNT_W) <= DEB_CYCLES) begin : g_cnt_w
    $error("btn_debounce: CNT_W too narrow for DEB_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    // Counter only advances across an unbroken run of disagreeing samples;
    // any agreeing sample (a bounce back) restarts the run.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Compare against the delayed copy so the pulse lands one cycle after
    // the level flop changes.
    pulse_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/dpu_operand_loader.sv
// Purpose : sequenced operand entry (Ain, Bin, ALUop) feeding the DPU data input.
// Latency : raw press -> din/stage update = 2 + DEB_CYCLES + 1 + 1 cycles.
// Backpressure: none; ENTER wins over BACK when both pulse in the same cycle.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   sw[3:0]              operand nibble (static switches, not synchronised)
//   btn_enter, btn_back  raw bouncing push-buttons
//   din[15:0]            {5'b0, op[2:0], b[3:0], a[3:0]}, registered
//   din_valid            high while a full operand set is loaded (RUN)
//   stage[1:0]           current entry state for display
module dpu_operand_loader
  import dpu_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sw,
  input  logic             btn_enter,
  input  logic             btn_back,
  output logic [DIN_W-1:0] din,
  output logic             din_valid,
  output logic [1:0]       stage
);

  logic enter_pulse;
  logic back_pulse;
  logic enter_level_unused;
  logic back_level_unused;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_enter),
    .level   (enter_level_unused),
    .pulse   (enter_pulse)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_back (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_back),
    .level   (back_level_unused),
    .pulse   (back_pulse)
  );

  state_t            state_q, state_d;
  logic [NIB_W-1:0]  a_q, a_d;
  logic [NIB_W-1:0]  b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;

    if (enter_pulse) begin
      // A coincident back pulse is deliberately discarded here.
      unique case (state_q)
        ST_A: begin
          a_d     = sw;
          state_d = ST_B;
        end
        ST_B: begin
          b_d     = sw;
          state_d = ST_OP;
        end
        ST_OP: begin
          op_d    = sw[OP_W-1:0];
          state_d = ST_RUN;
          valid_d = 1'b1;
        end
        ST_RUN: begin
          // Operands are kept; they are simply overwritten on the next pass.
          state_d = ST_A;
          valid_d = 1'b0;
        end
        default: state_d = ST_A;
      endcase
    end else if (back_pulse) begin
      unique case (state_q)
        ST_A:    state_d = ST_A;
        ST_B:    state_d = ST_A;
        ST_OP:   state_d = ST_B;
        ST_RUN: begin
          state_d = ST_OP;
          valid_d = 1'b0;
        end
        default: state_d = ST_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  // Pure wiring of flop outputs: no input reaches an output combinationally.
  assign din       = pack_din(a_q, b_q, op_q);
  assign din_valid = valid_q;
  assign stage     = state_q;

endmodule

// File: tb/tb_dpu_operand_loader.sv
module tb_dpu_operand_loader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw;
  logic        btn_enter;
  logic        btn_back;
  logic [15:0] din;
  logic        din_valid;
  logic [1:0]  stage;

  int checks = 0;
  int errors = 0;

  dpu_operand_loader #(
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_back  (btn_back),
    .din       (din),
    .din_valid (din_valid),
    .stage     (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={valid,stage,din}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [1:0] es,
                         input logic [15:0] ed);
    chk(tag, {din_valid, stage, din}, {ev, es, ed});
  endtask

  // Clean press: outputs must hold for 7 edges and may change only at the 8th.
  task automatic press(input string tag, input logic e, input logic bk, input logic [3:0] s);
    logic [18:0] pre;
    pre       = {din_valid, stage, din};
    sw        = s;
    btn_enter = e;
    btn_back  = bk;
    step(7);
    chk({tag, "_hold7"}, {din_valid, stage, din}, pre);
    step(1);
  endtask

  task automatic release_btns();
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    step(12);
  endtask

  initial begin
    rst_n     = 1'b0;
    sw        = 4'h0;
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk_out("reset", 1'b0, 2'b00, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_out("idle", 1'b0, 2'b00, 16'h0000);
    end

    // Full entry sequence; sw[3] must be dropped from op.
    press("ent_a", 1'b1, 1'b0, 4'h3);
    chk_out("ent_a", 1'b0, 2'b01, 16'h0003);
    release_btns();
    press("ent_b", 1'b1, 1'b0, 4'h5);
    chk_out("ent_b", 1'b0, 2'b10, 16'h0053);
    release_btns();
    press("ent_op", 1'b1, 1'b0, 4'b1101);
    chk_out("ent_op", 1'b1, 2'b11, 16'h0553);
    release_btns();
    chk_out("held_release", 1'b1, 2'b11, 16'h0553);

    // Back chain down to A, plus a no-op back in A.
    press("back_run", 1'b0, 1'b1, 4'h0);
    chk_out("back_run", 1'b0, 2'b10, 16'h0553);
    release_btns();
    press("back_op", 1'b0, 1'b1, 4'h0);
    chk_out("back_op", 1'b0, 2'b01, 16'h0553);
    release_btns();
    press("back_b", 1'b0, 1'b1, 4'h0);
    chk_out("back_b", 1'b0, 2'b00, 16'h0553);
    release_btns();
    press("back_a", 1'b0, 1'b1, 4'h0);
    chk_out("back_a", 1'b0, 2'b00, 16'h0553);
    release_btns();

    // Bouncing enter: 2-cycle toggles never survive 4 stable samples.
    sw = 4'h9;
    for (int i = 0; i < 5; i++) begin
      btn_enter = (i % 2 == 0);
      step(2);
    end
    chk_out("bounce_mid", 1'b0, 2'b00, 16'h0553);
    btn_enter = 1'b1;
    step(10);
    chk_out("bounce_done", 1'b0, 2'b01, 16'h0559);
    release_btns();
    chk_out("bounce_once", 1'b0, 2'b01, 16'h0559);

    // Simultaneous enter+back in B: enter wins, back never shows up later.
    press("both", 1'b1, 1'b1, 4'hA);
    chk_out("both", 1'b0, 2'b10, 16'h05A9);
    step(4);
    btn_enter = 1'b0;
    step(10);
    chk_out("both_back_dropped", 1'b0, 2'b10, 16'h05A9);
    btn_back = 1'b0;
    step(12);
    chk_out("both_after", 1'b0, 2'b10, 16'h05A9);

    // op 3'b110 loaded unchanged, then RUN+enter keeps operands.
    press("op6", 1'b1, 1'b0, 4'h6);
    chk_out("op6", 1'b1, 2'b11, 16'h06A9);
    release_btns();
    press("run_enter", 1'b1, 1'b0, 4'hF);
    chk_out("run_enter", 1'b0, 2'b00, 16'h06A9);
    release_btns();
    press("a1", 1'b1, 1'b0, 4'h1);
    chk_out("a1", 1'b0, 2'b01, 16'h06A1);
    release_btns();
    press("b2", 1'b1, 1'b0, 4'h2);
    chk_out("b2", 1'b0, 2'b10, 16'h0621);
    release_btns();
    press("op7", 1'b1, 1'b0, 4'h7);
    chk_out("op7", 1'b1, 2'b11, 16'h0721);
    release_btns();
    press("back_to_op", 1'b0, 1'b1, 4'h0);
    chk_out("back_to_op", 1'b0, 2'b10, 16'h0721);
    release_btns();

    // Reset in OP while the enter debounce counter is mid-count.
    sw        = 4'h4;
    btn_enter = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk_out("mid_reset", 1'b0, 2'b00, 16'h0000);
    rst_n = 1'b1;
    step(7);
    chk_out("post_reset_hold7", 1'b0, 2'b00, 16'h0000);
    step(1);
    chk_out("post_reset_pulse", 1'b0, 2'b01, 16'h0004);
    step(10);
    chk_out("post_reset_once", 1'b0, 2'b01, 16'h0004);
    release_btns();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpu_operand_loader.md
Name: dpu_operand_loader

Overview:
- Upstream stage of the DPU: replaces the raw 16-bit switch bank driving the DPU's 16-bit data input with a sequenced operand entry path.
- The user sets a 4-bit switch nibble and presses ENTER three times, loading Ain, then Bin, then ALUop; BACK steps one stage back.
- Outputs a registered 16-bit word with the DPU field layout, plus a valid flag and the current entry stage for display.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles before a debounced button level changes (≥2).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- sw  input  4  operand nibble from switches; treated as static and not synchronised.
- btn_enter  input  1  raw ENTER push-button, asynchronous and bouncing.
- btn_back  input  1  raw BACK push-button, asynchronous and bouncing.
- din  output  16  {5'b0, op[2:0], b[3:0], a[3:0]}: bits 3:0 Ain, 7:4 Bin, 10:8 ALUop, 15:11 zero.
- din_valid  output  1  high while a complete operand set is loaded (state RUN).
- stage  output  2  current FSM state encoding.

Behaviour:
- Reset: synchronous on the rising clk edge with rst_n=0. Clears a, b and op (so din=16'h0000), din_valid=0, stage=A (2'b00), synchroniser flops=0, debounced levels=0, counters=0.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce: the counter increments while the synchronised sample differs from the debounced level and clears on any matching sample. When the count reaches DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level produces a 1-cycle pulse, registered one cycle after the level change.
  - Falling edges produce no pulse. Holding a button produces exactly one pulse.
- FSM states: A=00, B=01, OP=10, RUN=11.
  - A + enter: a<=sw; go to B.
  - B + enter: b<=sw; go to OP.
  - OP + enter: op<=sw[2:0] (sw[3] ignored); go to RUN; din_valid<=1.
  - RUN + enter: go to A; din_valid<=0. a, b and op keep their old values until overwritten.
  - back in B→A, OP→B, RUN→OP (din_valid<=0). back in A is a no-op.
  - back does not modify any operand register.
- Simultaneous enter and back pulses in the same cycle: enter takes priority and back is dropped.
- Latency:
  - Registers and outputs update on the clock edge after the cycle in which the enter pulse is high.
  - Raw press to din change, bounce-free: 2 (sync) + DEB_CYCLES (debounce) + 1 (edge) + 1 (register) cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- op values 3'b110 and 3'b111 are loaded unchanged. Their ALU meaning is defined downstream.
- Reset mid-entry (any state, any counter value) returns the block to the full reset state in one cycle. A button held through reset produces a pulse after release-free debounce, because the debounced level restarts at 0.

Decomposition:
- Shared package `dpu_pkg`:
  - State encodings ST_A, ST_B, ST_OP, ST_RUN.
  - Field positions AIN_LSB=0, BIN_LSB=4, OP_LSB=8, OP_W=3.
  - DIN_W=16.
- One sub-module, `btn_debounce`: synchroniser, debounce counter and rising-edge pulse. Parameters DEB_CYCLES and CNT_W; ports clk, rst_n, btn_raw, level, pulse. It is instantiated twice (enter, back).
- FSM and operand registers live in the top level.

Test Plan (DEB_CYCLES=4):
- Reset then idle 20 cycles → din=16'h0000, din_valid=0, stage=00, no pulses.
- sw=4'h3 enter; sw=4'h5 enter; sw=4'b1101 enter → din=16'h0553 (sw[3] dropped), din_valid=1, stage=11. Each update occurs exactly 8 cycles after the raw press edge.
- Bouncing enter (toggle every 2 cycles for 10 cycles, then hold high 10 cycles) in state A with sw=4'h9 → exactly one advance; a=9, stage=01.
- In RUN, press back → stage=10, din_valid=0, din unchanged. Press back again → stage=01. Press back twice more → stage=00, and the extra back is a no-op.
- enter and back pressed on the same cycle in B with sw=4'hA → b=A, stage=10. The back press is ignored and does not register later.
- Assert rst_n=0 for one cycle in OP with enter debounce counter mid-count → next cycle din=0, stage=00, din_valid=0. A held enter then yields one pulse 8 cycles after rst_n returns high.
